// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, scan-tap payload type and the frame-buffer
// address-width check used by vga_scan_addr_gen.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam bit SYNC_POL_LOW = 1'b0;

    // Raster position counters; wide enough for any total up to 1024.
    localparam int unsigned CNT_W = 10;

    // Everything that must stay aligned with the BRAM read data.
    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             valid;
        logic             fs;
        logic             ls;
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] vc;
    } scan_tap_t;

    localparam int unsigned TAP_W = $bits(scan_tap_t);

    // True when the downscaled buffer fits in an ADDR_W-bit address space.
    function automatic bit addr_fits(input int unsigned h_act, input int unsigned v_act,
                                     input int unsigned s, input int unsigned aw);
        longint unsigned need;
        need = longint'(h_act >> s) * longint'(v_act >> s);
        return need <= (64'd1 << aw);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register; each stage resets to RST_VAL so sync
// bits come out deasserted while the pipeline refills.
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_addr_gen.sv
// VGA raster counters, sync/valid decode and downscaled frame-buffer read
// address; sync/position outputs are delayed to line up with BRAM douta.
module vga_scan_addr_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter bit          SYNC_POL    = SYNC_POL_LOW,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [CNT_W-1:0]  h_cnt,
    output logic [CNT_W-1:0]  v_cnt,
    output logic              frame_start,
    output logic              line_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PIPE     = 1 + RD_LATENCY;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Buffer line length; its set bits select the shift-add terms below.
    localparam logic [ADDR_W-1:0] LINE_W  = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

    localparam scan_tap_t TAP_RST = '{
        hs:    ~SYNC_POL,
        vs:    ~SYNC_POL,
        valid: 1'b0,
        fs:    1'b0,
        ls:    1'b0,
        hc:    '0,
        vc:    '0
    };

    if (!addr_fits(H_ACTIVE, V_ACTIVE, SCALE_SHIFT, ADDR_W)) begin : g_addr_chk
        $error("vga_scan_addr_gen: ADDR_W too narrow for the scaled frame buffer");
    end

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;

    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    logic raw_hs;
    logic raw_vs;
    logic raw_valid;
    logic raw_fs;
    logic raw_ls;

    always_comb begin
        raw_hs    = (hc >= HS_START) && (hc < HS_END);
        raw_vs    = (vc >= VS_START) && (vc < VS_END);
        raw_valid = (hc < H_ACT) && (vc < V_ACT);
        raw_fs    = (hc == '0) && (vc == '0);
        raw_ls    = (hc == '0) && (vc < V_ACT);
    end

    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        row    = ADDR_W'(vc >> SCALE_SHIFT);
        col    = ADDR_W'(hc >> SCALE_SHIFT);
        addr_d = '0;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            if (LINE_W[i]) begin
                addr_d = addr_d + (row << i);
            end
        end
        addr_d = addr_d + col;
        if (!raw_valid) begin
            addr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
        end else begin
            pixel_addr <= addr_d;
        end
    end

    // Sync level is resolved before the delay so reset fills it deasserted.
    scan_tap_t        tap_in;
    scan_tap_t        tap_out;
    logic [TAP_W-1:0] tap_out_vec;

    always_comb begin
        tap_in.hs    = raw_hs ? SYNC_POL : ~SYNC_POL;
        tap_in.vs    = raw_vs ? SYNC_POL : ~SYNC_POL;
        tap_in.valid = raw_valid;
        tap_in.fs    = raw_fs;
        tap_in.ls    = raw_ls;
        tap_in.hc    = hc;
        tap_in.vc    = vc;
    end

    vga_delay_line #(
        .WIDTH   (TAP_W),
        .DEPTH   (PIPE),
        .RST_VAL (TAP_RST)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tap_in),
        .dout (tap_out_vec)
    );

    assign tap_out     = scan_tap_t'(tap_out_vec);
    assign hsync       = tap_out.hs;
    assign vsync       = tap_out.vs;
    assign valid       = tap_out.valid;
    assign frame_start = tap_out.fs;
    assign line_start  = tap_out.ls;
    assign h_cnt       = tap_out.hc;
    assign v_cnt       = tap_out.vc;

endmodule
